// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: WIDTH/BLOCK register-separated slices,
// carry registered between slices, valid/ready handshake with per-slice backpressure.
module pipelined_cla_adder #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned BLOCK = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned STAGES = WIDTH / BLOCK;
  localparam int unsigned NGRP   = BLOCK / 4;

  // Slice sum with 4-bit group P/G; returns {carry into MSB, carry out, sum}.
  function automatic logic [BLOCK+1:0] cla_slice(input logic [BLOCK-1:0] a,
                                                 input logic [BLOCK-1:0] b,
                                                 input logic             cin);
    logic [BLOCK-1:0] p, g, c;
    logic [NGRP-1:0]  gp, gg;
    logic [NGRP:0]    gc;
    logic             t, acc, tall;
    p = a ^ b;
    g = a & b;
    for (int j = 0; j < NGRP; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1]) |
              (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end
    // Each group carry is a flat sum-of-products over group P/G terms.
    gc[0] = cin;
    for (int j = 1; j <= NGRP; j++) begin
      acc  = 1'b0;
      tall = cin;
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & gp[m];
        acc  = acc | t;
        tall = tall & gp[i];
      end
      gc[j] = acc | tall;
    end
    for (int j = 0; j < NGRP; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j]) |
                 (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end
    return {c[BLOCK-1], gc[NGRP], p ^ c};
  endfunction

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_c;
  logic [WIDTH-1:0]  r_x   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic              r_ovf;
  logic              r_zero;

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_ld;
  logic [STAGES-1:0] w_cn;
  logic              w_cmsb [STAGES];
  logic [WIDTH-1:0]  w_xn   [STAGES];
  logic [WIDTH-1:0]  w_bn   [STAGES];
  logic [TAG_W-1:0]  w_tn   [STAGES];
  logic              w_c0;

  assign w_c0     = in_op[1] ? (in_cin ^ in_op[0]) : in_op[0];
  assign in_ready = rst_n & (~r_v[0] | w_adv[0]);

  // r_x carries the unsummed A bits low and rotates finished sum blocks in at the top.
  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    logic [WIDTH-1:0] w_xi;
    logic [WIDTH-1:0] w_bi;
    logic             w_ci;
    logic [BLOCK+1:0] w_res;

    if (k == 0) begin : g_first
      assign w_xi    = in_a;
      assign w_bi    = in_op[0] ? ~in_b : in_b;
      assign w_ci    = w_c0;
      assign w_tn[k] = in_tag;
      assign w_ld[k] = in_valid & in_ready;
    end else begin : g_next
      assign w_xi    = r_x[k-1];
      assign w_bi    = r_b[k-1];
      assign w_ci    = r_c[k-1];
      assign w_tn[k] = r_tag[k-1];
      assign w_ld[k] = w_adv[k-1];
    end

    if (k == STAGES - 1) begin : g_last_adv
      assign w_adv[k] = r_v[k] & out_ready;
    end else begin : g_mid_adv
      assign w_adv[k] = r_v[k] & (~r_v[k+1] | w_adv[k+1]);
    end

    assign w_res     = cla_slice(w_xi[BLOCK-1:0], w_bi[BLOCK-1:0], w_ci);
    assign w_xn[k]   = WIDTH'({w_res[BLOCK-1:0], w_xi} >> BLOCK);
    assign w_bn[k]   = w_bi >> BLOCK;
    assign w_cn[k]   = w_res[BLOCK];
    assign w_cmsb[k] = w_res[BLOCK+1];
  end

  // Slice registers: valid sets on load, clears on advance without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      r_c <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_x[k]   <= '0;
        r_b[k]   <= '0;
        r_tag[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_ld[k]) begin
          r_v[k]   <= 1'b1;
          r_c[k]   <= w_cn[k];
          r_x[k]   <= w_xn[k];
          r_b[k]   <= w_bn[k];
          r_tag[k] <= w_tn[k];
        end else if (w_adv[k]) begin
          r_v[k] <= 1'b0;
        end
      end
    end
  end

  // Flags are produced by the last slice alongside the assembled sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_ld[STAGES-1]) begin
      r_ovf  <= w_cmsb[STAGES-1] ^ w_cn[STAGES-1];
      r_zero <= (w_xn[STAGES-1] == '0);
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign out_sum   = r_x[STAGES-1];
  assign out_cout  = r_c[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];
  assign out_ovf   = r_ovf;
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: vector table, latency, backpressure, random traffic
// and mid-flight reset, all results checked through an in-order scoreboard.
module tb_pipelined_cla_adder;

  localparam int unsigned WIDTH  = 64;
  localparam int unsigned BLOCK  = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int unsigned STAGES = WIDTH / BLOCK;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } res_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             cin;
    logic [TAG_W-1:0] tag;
    res_t             exp;
  } vec_t;

  logic             clk, rst_n;
  logic             in_valid, in_ready, in_cin;
  logic [WIDTH-1:0] in_a, in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_cout, out_ovf, out_zero;
  logic [WIDTH-1:0] out_sum;
  logic [TAG_W-1:0] out_tag;

  pipelined_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_op(in_op), .in_cin(in_cin), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   acc_cnt  = 0;
  int   out_cnt  = 0;
  res_t sb_q[$];
  res_t cur_exp;
  res_t mon_exp, mon_got;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Independent reference: wide integer add with sign-rule overflow.
  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [1:0] op, input logic cin,
                                 input logic [TAG_W-1:0] tag);
    logic [WIDTH-1:0] bb;
    logic             c0;
    logic [WIDTH:0]   full;
    res_t             r;
    case (op)
      2'b00:   begin bb = b;  c0 = 1'b0; end
      2'b01:   begin bb = ~b; c0 = 1'b1; end
      2'b10:   begin bb = b;  c0 = cin;  end
      default: begin bb = ~b; c0 = ~cin; end
    endcase
    full   = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(c0);
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    r.zero = (full[WIDTH-1:0] == '0);
    r.tag  = tag;
    return r;
  endfunction

  function automatic vec_t mk(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic [1:0] op, input logic cin, input logic [TAG_W-1:0] tag,
                              input logic [WIDTH-1:0] sum, input logic cout,
                              input logic ovf, input logic zero);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.cin = cin; v.tag = tag;
    v.exp.sum = sum; v.exp.cout = cout; v.exp.ovf = ovf; v.exp.zero = zero; v.exp.tag = tag;
    return v;
  endfunction

  function automatic logic [WIDTH-1:0] rand_opnd();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.a   = rand_opnd();
    v.b   = rand_opnd();
    v.op  = 2'($urandom_range(0, 3));
    v.cin = 1'($urandom_range(0, 1));
    v.tag = TAG_W'($urandom_range(0, 15));
    v.exp = model(v.a, v.b, v.op, v.cin, v.tag);
    return v;
  endfunction

  // Monitor: transfers are decided mid-cycle, ahead of the edge that commits them.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_cnt++;
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_out: tag %0d sum %h with nothing outstanding", out_tag, out_sum);
        end else begin
          mon_exp      = sb_q.pop_front();
          mon_got.sum  = out_sum;
          mon_got.cout = out_cout;
          mon_got.ovf  = out_ovf;
          mon_got.zero = out_zero;
          mon_got.tag  = out_tag;
          check("result{sum,cout,ovf,zero,tag}", 128'(mon_got), 128'(mon_exp));
        end
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(cur_exp);
        acc_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input vec_t v);
    in_a = v.a; in_b = v.b; in_op = v.op; in_cin = v.cin; in_tag = v.tag;
    cur_exp = v.exp;
  endtask

  task automatic send(input vec_t v);
    int n;
    n = 0;
    set_in(v);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 200) begin
        $display("FAIL send_timeout: in_ready stuck at 0 for tag %0d", v.tag);
        $fatal(1, "input handshake never completed");
      end
      @(negedge clk);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sb_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("drain_empty", 128'(sb_q.size()), 128'(0));
  endtask

  vec_t vecs[12];
  vec_t bp[8];
  vec_t v;
  int   lat, base;

  initial begin
    vecs[0]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b0, 4'd3, 64'h0, 1'b1, 1'b0, 1'b1);
    vecs[1]  = mk(64'h8000_0000_0000_0000, 64'h1, 2'b01, 1'b0, 4'd1,
                  64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0);
    vecs[2]  = mk(64'h0000_0000_0000_FFFF, 64'h0, 2'b10, 1'b1, 4'd2,
                  64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
    vecs[3]  = mk(64'h0, 64'h0, 2'b11, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 2'b00, 1'b0, 4'd5,
                  64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
    vecs[5]  = mk(64'h5, 64'h5, 2'b01, 1'b0, 4'd6, 64'h0, 1'b1, 1'b0, 1'b1);
    vecs[6]  = mk(64'h1, 64'h2, 2'b00, 1'b1, 4'd7, 64'h3, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mk(64'hA, 64'h3, 2'b11, 1'b0, 4'd8, 64'h7, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(64'h0, 64'h1, 2'b01, 1'b0, 4'd9, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 2'b00, 1'b0, 4'd10,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b1, 4'd11,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(64'h0001_0000_0000_0000, 64'h0, 2'b11, 1'b1, 4'd12,
                  64'h0000_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_cin = 1'b0; in_tag = '0; cur_exp = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_sum", 128'(out_sum), 128'(0));
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    check("post_rst_out_valid", 128'(out_valid), 128'(0));

    // Latency from the accept edge to out_valid
    tick();
    out_ready = 1'b1;
    set_in(vecs[0]);
    in_valid = 1'b1;
    @(negedge clk);
    tick();
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("latency", 128'(lat), 128'(STAGES));
    drain();

    // Vector table, back to back
    for (int i = 0; i < 12; i++) send(vecs[i]);
    drain();

    // Backpressure: 8 ops queued against a stalled consumer
    for (int i = 0; i < 8; i++) begin
      bp[i].a   = {$urandom, $urandom};
      bp[i].b   = {$urandom, $urandom};
      bp[i].op  = 2'(i);
      bp[i].cin = 1'(i);
      bp[i].tag = TAG_W'(i);
      bp[i].exp = model(bp[i].a, bp[i].b, bp[i].op, bp[i].cin, bp[i].tag);
    end
    tick();
    out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        for (int i = 0; i < 8; i++) send(bp[i]);
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("bp_hold_sum_early", 128'(out_sum), 128'(bp[0].exp.sum));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_accepts_when_full", 128'(acc_cnt - base), 128'(STAGES));
        check("bp_in_ready_low", 128'(in_ready), 128'(0));
        check("bp_out_valid", 128'(out_valid), 128'(1));
        check("bp_hold_tag", 128'(out_tag), 128'(0));
        check("bp_hold_sum", 128'(out_sum), 128'(bp[0].exp.sum));
        tick();
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random valid/ready
    for (int c = 0; c < 300; c++) begin
      v = rand_vec();
      set_in(v);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    drain();

    // Reset with three ops in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(rand_vec());
    repeat (2) tick();
    check("pre_rst_out_valid", 128'(out_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    base = out_cnt;
    tick();
    send(rand_vec());
    drain();
    check("post_rst_result_count", 128'(out_cnt - base), 128'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
